// File: rtl/adc_cal_pkg.sv
// Shared types and constants for the ADC366x receiver delay calibration block.
package adc_cal_pkg;

  localparam int TAPS = 32;
  localparam int LOAD_LEN = 4;
  localparam logic [15:0] DEF_PAT = 16'hA5A5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_MEASURE,
    S_NEXT,
    S_APPLY,
    S_FINISH
  } state_e;

endpackage

// File: rtl/adc_cal_run.sv
// Longest passing-run tracker across a tap scan; ties keep the earliest run,
// and runs never wrap from the last tap back to tap 0.
module adc_cal_run
  import adc_cal_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clear_i,
  input  logic       step_i,
  input  logic       pass_i,
  input  logic [4:0] tap_i,
  output logic [4:0] best_start_o,
  output logic [5:0] best_len_o
);

  logic [5:0] cur_len_q, cur_len_d;
  logic [4:0] cur_start_q, cur_start_d;
  logic [5:0] best_len_q, best_len_d;
  logic [4:0] best_start_q, best_start_d;
  logic [5:0] new_len;
  logic [4:0] new_start;

  always_comb begin
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    new_len      = cur_len_q + 6'd1;
    new_start    = (cur_len_q == 6'd0) ? tap_i : cur_start_q;
    if (clear_i) begin
      cur_len_d    = '0;
      cur_start_d  = '0;
      best_len_d   = '0;
      best_start_d = '0;
    end else if (step_i) begin
      if (pass_i) begin
        cur_len_d   = new_len;
        cur_start_d = new_start;
        // Strict compare so an equal-length later run never displaces the first.
        if (new_len > best_len_q) begin
          best_len_d   = new_len;
          best_start_d = new_start;
        end
      end else begin
        cur_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else begin
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/adc366x_dly_cal.sv
// ADC366x receiver delay-tap calibration: scans all taps, picks the centre of the
// longest passing run. Optional pass bitmap output under macro ADC_CAL_BITMAP_EN.
module adc366x_dly_cal
  import adc_cal_pkg::*;
#(
  parameter int          SETTLE  = 64,
  parameter int          WIN     = 256,
  parameter int          TMO     = 4096,
  parameter int          MIN_RUN = 4,
  parameter logic [15:0] PAT     = DEF_PAT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        smp_vld_i,
  input  logic [31:0] smp_dat_i,
  output logic [5:0]  dly_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [4:0]  tap_o,
  output logic [5:0]  run_o
`ifdef ADC_CAL_BITMAP_EN
  ,
  output logic [31:0] pass_map_o
`endif
);

  state_e      state_q, state_d;
  logic [4:0]  tap_q, tap_d;
  logic [4:0]  prev_tap_q, prev_tap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        pass_q, pass_d;
  logic        final_q, final_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic [5:0]  run_q, run_d;
`ifdef ADC_CAL_BITMAP_EN
  logic [31:0] map_q, map_d;
`endif

  logic        trk_clear;
  logic        trk_step;
  logic [4:0]  best_start;
  logic [5:0]  best_len;
  logic [4:0]  half_len;
  logic        abortable;

  adc_cal_run u_run (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (trk_clear),
    .step_i       (trk_step),
    .pass_i       (pass_q),
    .tap_i        (tap_q),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    prev_tap_d = prev_tap_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    pass_d     = pass_q;
    final_d    = final_q;
    done_d     = done_q;
    fail_d     = fail_q;
    run_d      = run_q;
`ifdef ADC_CAL_BITMAP_EN
    map_d      = map_q;
`endif
    trk_clear  = 1'b0;
    trk_step   = 1'b0;
    half_len   = 5'((best_len - 6'd1) >> 1);
    abortable  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          prev_tap_d = tap_q;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          run_d      = '0;
          tap_d      = '0;
          cnt_d      = '0;
          final_d    = 1'b0;
          trk_clear  = 1'b1;
`ifdef ADC_CAL_BITMAP_EN
          map_d      = '0;
`endif
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        abortable = !final_q;
        if (cnt_q == 16'(LOAD_LEN - 1)) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = final_q ? S_FINISH : S_SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SETTLE: begin
        abortable = 1'b1;
        if (cnt_q == 16'(SETTLE - 1)) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_MEASURE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_MEASURE: begin
        abortable = 1'b1;
        // The timeout counts consecutive idle cycles, so any valid sample rearms it.
        if (smp_vld_i) begin
          tmo_d = '0;
          if (smp_dat_i != {PAT, PAT}) begin
            pass_d  = 1'b0;
            state_d = S_NEXT;
          end else if (cnt_q == 16'(WIN - 1)) begin
            pass_d  = 1'b1;
            state_d = S_NEXT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (tmo_q == 16'(TMO - 1)) begin
          pass_d  = 1'b0;
          state_d = S_NEXT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_NEXT: begin
        abortable = 1'b1;
        trk_step  = 1'b1;
        cnt_d     = '0;
`ifdef ADC_CAL_BITMAP_EN
        if (pass_q) begin
          map_d[tap_q] = 1'b1;
        end
`endif
        if (tap_q == 5'(TAPS - 1)) begin
          state_d = S_APPLY;
        end else begin
          tap_d   = tap_q + 5'd1;
          state_d = S_LOAD;
        end
      end
      S_APPLY: begin
        abortable = 1'b1;
        run_d     = best_len;
        final_d   = 1'b1;
        cnt_d     = '0;
        state_d   = S_LOAD;
        if (best_len >= 6'(MIN_RUN)) begin
          tap_d  = best_start + half_len;
          done_d = 1'b1;
        end else begin
          tap_d  = prev_tap_q;
          fail_d = 1'b1;
        end
      end
      S_FINISH: begin
        final_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort restores the pre-calibration tap through one final load sequence.
    if (abort_i && abortable) begin
      tap_d   = prev_tap_q;
      fail_d  = 1'b1;
      done_d  = 1'b0;
      final_d = 1'b1;
      cnt_d   = '0;
      state_d = S_LOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      prev_tap_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      pass_q     <= 1'b0;
      final_q    <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      prev_tap_q <= prev_tap_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      pass_q     <= pass_d;
      final_q    <= final_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      run_q      <= run_d;
    end
  end

`ifdef ADC_CAL_BITMAP_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign pass_map_o = map_q;
`endif

  assign dly_o  = {state_q == S_LOAD, tap_q};
  assign tap_o  = tap_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign fail_o = fail_q;
  assign run_o  = run_q;

endmodule

// File: doc/adc366x_dly_cal.md
ADC366X_DLY_CAL -- requirements
Module: adc366x_dly_cal

Interface
REQ-001 SHALL have parameter SETTLE, default 64, cycles waited after each tap load before measuring.
REQ-002 SHALL have parameter WIN, default 256, valid samples compared per tap.
REQ-003 SHALL have parameter TMO, default 4096, cycles per tap without a valid sample before the tap is declared failing.
REQ-004 SHALL have parameter MIN_RUN, default 4, minimum passing-run length for success.
REQ-005 SHALL have parameter PAT, default 16'hA5A5, ADC test pattern expected on both channels.
REQ-006 clk_i  in  1  single clock (cfg_clk domain); all logic rising-edge.
REQ-007 rstn_i  in  1  reset, asynchronous, active-low.
REQ-008 start_i  in  1  single-cycle calibration request.
REQ-009 abort_i  in  1  single-cycle abort request.
REQ-010 smp_vld_i  in  1  receiver frame-valid, already synchronous to clk_i.
REQ-011 smp_dat_i  in  32  receiver parallel data {chB,chA}, qualified by smp_vld_i.
REQ-012 dly_o  out  6  receiver delay control: [4:0] tap, [5] load strobe.
REQ-013 busy_o  out  1  calibration in progress.
REQ-014 done_o  out  1  last calibration succeeded (sticky until next start).
REQ-015 fail_o  out  1  last calibration failed or aborted (sticky until next start).
REQ-016 tap_o  out  5  currently applied tap.
REQ-017 run_o  out  6  length of best passing run found (0..32).

Function
REQ-018 FSM states SHALL be IDLE, LOAD, SETTLE, MEASURE, NEXT, APPLY, FINISH.
REQ-019 IDLE: start_i=1 SHALL capture current tap as prev_tap, clear done_o/fail_o/run_o, set tap=0, go LOAD; start_i while busy_o=1 SHALL be ignored.
REQ-020 LOAD SHALL last exactly 4 cycles with dly_o[5]=1 and dly_o[4:0]=tap; dly_o[5]=0 in every other state.
REQ-021 SETTLE SHALL count SETTLE cycles, ignoring samples, then enter MEASURE.
REQ-022 MEASURE SHALL count valid samples; a sample mismatches if smp_dat_i != {PAT,PAT}; tap passes only if WIN valid samples seen with zero mismatches.
REQ-023 MEASURE SHALL end early (tap fails) on first mismatch, or if TMO consecutive cycles pass without smp_vld_i.
REQ-024 NEXT SHALL update running-best tracker in one cycle; tap 31 -> APPLY, else tap+1 -> LOAD.
REQ-025 Tracker: current run increments on pass, resets to 0 on fail; best updated only when current run strictly exceeds best (ties keep lowest-start run); no wrap from tap 31 to tap 0.
REQ-026 APPLY: if best >= MIN_RUN, tap = best_start + (best-1)/2 (floor) and done_o=1; else tap = prev_tap and fail_o=1; then LOAD sequence (4 cycles) -> FINISH.
REQ-027 FINISH SHALL deassert busy_o and return to IDLE next cycle.
REQ-028 abort_i in any busy state SHALL set tap=prev_tap, fail_o=1, enter LOAD then FINISH; abort_i in IDLE ignored; abort_i and start_i together in IDLE: start wins.
REQ-029 busy_o SHALL be 1 from cycle after accepted start through FINISH inclusive.
REQ-030 tap_o SHALL equal dly_o[4:0] at all times; run_o SHALL hold best run after APPLY.

Reset
REQ-031 rstn_i low SHALL asynchronously force: state IDLE, dly_o=6'h00, tap_o=0, busy_o=0, done_o=0, fail_o=0, run_o=0, all counters 0, prev_tap=0.
REQ-032 Reset mid-calibration SHALL abandon scan with no load strobe issued on release.

Configuration
REQ-033 Macro ADC_CAL_BITMAP_EN defined: output pass_map_o [31:0] SHALL exist, cleared on accepted start, bit n set in NEXT when tap n passed, reset 0.
REQ-034 Macro undefined: pass_map_o port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-035 Package adc_cal_pkg SHALL hold state enum, TAPS=32, LOAD_LEN=4, default PAT.
REQ-036 Run tracker SHALL be sub-module adc_cal_run (inputs: clear, step, pass, tap; outputs: best_start, best_len).

Verification
REQ-037 Taps 10..19 pass, others mismatch -> tap_o=14, run_o=10, done_o=1, fail_o=0.
REQ-038 Runs 3..6 (4) and 20..23 (4) pass -> tie keeps first, tap_o=4, run_o=4.
REQ-039 Only taps 0..2 pass, prev_tap=7 -> fail_o=1, tap_o=7, run_o=3, final load strobe 4 cycles with dly_o[4:0]=7.
REQ-040 smp_vld_i held 0 -> each tap times out after TMO cycles, fail_o=1, 32 load strobes plus restore.
REQ-041 abort_i during MEASURE of tap 9 -> restore prev_tap, fail_o=1, busy_o falls after 6 cycles; start_i during busy ignored.
REQ-042 rstn_i asserted mid-SETTLE -> all outputs zero immediately; with ADC_CAL_BITMAP_EN, pass_map_o=0.
